// File: rtl/tawas_raccoon_target.sv
// tawas_raccoon_target: Raccoon ring target that claims windowed requests and inserts responses
module tawas_raccoon_target #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [78:0] RaccIn,
    output logic [78:0] RaccOut,
    output logic        MEM_REQ,
    output logic        MEM_WR,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_MASK,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_next;
    logic [78:0] racc_in, out_next;
    logic [7:0] id_q;
    logic [31:0] rdata_q;
    logic hit, capture, done;
    assign hit = racc_in[78] && !racc_in[76] &&
                 ((racc_in[31:0] & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
    always_comb begin
        state_next = state;
        out_next = racc_in[78] ? racc_in : '0;
        capture = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: if (hit) begin
                capture = 1'b1;
                out_next = '0;
                state_next = ACCESS;
            end
            ACCESS: if (MEM_REQ && MEM_ACK) begin
                done = 1'b1;
                state_next = RESP;
            end
            RESP: if (!racc_in[78]) begin
                // Ring traffic has priority; insert only into an empty slot
                out_next = {1'b1, MEM_WR, 1'b1, id_q, MEM_MASK, rdata_q, MEM_ADDR};
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            racc_in <= '0;
            RaccOut <= '0;
            MEM_REQ <= 1'b0;
            MEM_WR <= 1'b0;
            MEM_ADDR <= '0;
            MEM_MASK <= '0;
            MEM_WDATA <= '0;
            id_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            racc_in <= RaccIn;
            RaccOut <= out_next;
            if (capture) begin
                MEM_REQ <= 1'b1;
                MEM_WR <= racc_in[77];
                id_q <= racc_in[75:68];
                MEM_MASK <= racc_in[67:64];
                MEM_WDATA <= racc_in[63:32];
                MEM_ADDR <= racc_in[31:0];
            end
            if (done) begin
                MEM_REQ <= 1'b0;
                rdata_q <= MEM_RDATA;
            end
        end
    end
endmodule

// File: tb/tb_tawas_raccoon_target.sv
// tb_tawas_raccoon_target: directed self-checking bench for the Raccoon ring target
module tb_tawas_raccoon_target;
    logic        CLK = 0;
    logic        RST = 0;
    logic [78:0] RaccIn = '0;
    logic [78:0] RaccOut;
    logic        MEM_REQ, MEM_WR;
    logic [31:0] MEM_ADDR, MEM_WDATA;
    logic [3:0]  MEM_MASK;
    logic        MEM_ACK = 0;
    logic [31:0] MEM_RDATA = '0;
    int total = 0;
    int fails = 0;
    logic [78:0] n_pkt [5];
    logic [78:0] pa, pb;

    tawas_raccoon_target #(.ADDR_BASE(32'h8000_0000), .ADDR_MASK(32'hFFFF_0000)) dut (
        .CLK(CLK), .RST(RST), .RaccIn(RaccIn), .RaccOut(RaccOut),
        .MEM_REQ(MEM_REQ), .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_MASK(MEM_MASK),
        .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    function automatic logic [78:0] mk(input logic wr, input logic resp, input logic [7:0] id,
                                       input logic [3:0] m, input logic [31:0] d, input logic [31:0] a);
        return {1'b1, wr, resp, id, m, d, a};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("reset_raccout", RaccOut, '0);
        chk("reset_req", {78'd0, MEM_REQ}, '0);
        chk("reset_addr", {47'd0, MEM_ADDR}, '0);
        RST = 1;
        tick();
        // read hit, memory acks three cycles after the request
        RaccIn = mk(0, 0, 8'h02, 4'hF, 32'h0, 32'h8000_0010);
        tick();
        RaccIn = '0;
        tick();
        chk("rd_req", {78'd0, MEM_REQ}, 79'd1);
        chk("rd_addr", {47'd0, MEM_ADDR}, {47'd0, 32'h8000_0010});
        chk("rd_wr", {78'd0, MEM_WR}, '0);
        chk("rd_slot_zero", RaccOut, '0);
        tick();
        tick();
        chk("rd_req_held", {78'd0, MEM_REQ}, 79'd1);
        MEM_ACK = 1;
        MEM_RDATA = 32'hDEADBEEF;
        tick();
        MEM_ACK = 0;
        chk("rd_req_drop", {78'd0, MEM_REQ}, '0);
        tick();
        chk("rd_resp", RaccOut, mk(0, 1, 8'h02, 4'hF, 32'hDEADBEEF, 32'h8000_0010));
        // write hit with same-cycle ack
        RaccIn = mk(1, 0, 8'h05, 4'b0011, 32'h0000_1234, 32'h8000_0004);
        tick();
        RaccIn = '0;
        tick();
        chk("wr_wdata", {47'd0, MEM_WDATA}, {47'd0, 32'h0000_1234});
        chk("wr_mask", {75'd0, MEM_MASK}, {75'd0, 4'b0011});
        chk("wr_wr", {78'd0, MEM_WR}, 79'd1);
        MEM_ACK = 1;
        MEM_RDATA = 32'h0BAD_F00D;
        tick();
        MEM_ACK = 0;
        tick();
        chk("wr_resp_hdr", {76'd0, RaccOut[78:76]}, {76'd0, 3'b111});
        chk("wr_resp", RaccOut, mk(1, 1, 8'h05, 4'b0011, 32'h0BAD_F00D, 32'h8000_0004));
        // miss and response pass-through
        pa = mk(0, 0, 8'h07, 4'hF, 32'h11, 32'h4000_0000);
        pb = mk(0, 1, 8'h09, 4'hF, 32'h22, 32'h8000_0000);
        RaccIn = pa;
        tick();
        RaccIn = pb;
        tick();
        chk("miss_fwd", RaccOut, pa);
        chk("miss_noreq", {78'd0, MEM_REQ}, '0);
        RaccIn = '0;
        tick();
        chk("resp_fwd", RaccOut, pb);
        chk("resp_noreq", {78'd0, MEM_REQ}, '0);
        tick();
        chk("empty_after", RaccOut, '0);
        // busy retry while the first access is outstanding
        pb = mk(1, 0, 8'h03, 4'h1, 32'h55, 32'h8000_0030);
        RaccIn = mk(0, 0, 8'h01, 4'hF, 32'h0, 32'h8000_0020);
        tick();
        RaccIn = pb;
        tick();
        chk("busy_capture", RaccOut, '0);
        RaccIn = '0;
        tick();
        chk("busy_fwd", RaccOut, pb);
        chk("busy_resp_bit", {78'd0, RaccOut[76]}, '0);
        chk("busy_addr_held", {47'd0, MEM_ADDR}, {47'd0, 32'h8000_0020});
        chk("busy_req_held", {78'd0, MEM_REQ}, 79'd1);
        MEM_ACK = 1;
        MEM_RDATA = 32'h1357_9BDF;
        tick();
        MEM_ACK = 0;
        tick();
        chk("busy_first_resp", RaccOut, mk(0, 1, 8'h01, 4'hF, 32'h1357_9BDF, 32'h8000_0020));
        // blocked insertion behind five back-to-back non-hit packets
        for (int i = 0; i < 5; i++) n_pkt[i] = mk(0, 0, 8'h20 + 8'(i), 4'hF, 32'(i), 32'h4000_0000 + 32'(i));
        RaccIn = mk(0, 0, 8'h0A, 4'hF, 32'h0, 32'h8000_0040);
        tick();
        RaccIn = '0;
        tick();
        MEM_ACK = 1;
        MEM_RDATA = 32'hA5A5_5A5A;
        RaccIn = n_pkt[0];
        tick();
        MEM_ACK = 0;
        for (int k = 1; k <= 5; k++) begin
            RaccIn = (k < 5) ? n_pkt[k] : '0;
            tick();
            chk($sformatf("blk_fwd%0d", k - 1), RaccOut, n_pkt[k - 1]);
        end
        tick();
        chk("blk_resp", RaccOut, mk(0, 1, 8'h0A, 4'hF, 32'hA5A5_5A5A, 32'h8000_0040));
        // reset in the middle of an access
        RaccIn = mk(0, 0, 8'h0B, 4'hF, 32'h0, 32'h8000_0050);
        tick();
        RaccIn = '0;
        tick();
        chk("rst_pre_req", {78'd0, MEM_REQ}, 79'd1);
        RST = 0;
        tick();
        RST = 1;
        chk("rst_req", {78'd0, MEM_REQ}, '0);
        chk("rst_out", RaccOut, '0);
        MEM_ACK = 1;
        MEM_RDATA = 32'hFFFF_FFFF;
        tick();
        MEM_ACK = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst_no_resp%0d", k), RaccOut, '0);
        end
        RaccIn = mk(1, 0, 8'h0C, 4'hF, 32'h77, 32'h8000_0060);
        tick();
        RaccIn = '0;
        tick();
        chk("post_rst_req", {78'd0, MEM_REQ}, 79'd1);
        chk("post_rst_addr", {47'd0, MEM_ADDR}, {47'd0, 32'h8000_0060});
        MEM_ACK = 1;
        MEM_RDATA = 32'h2468_ACE0;
        tick();
        MEM_ACK = 0;
        tick();
        chk("post_rst_resp", RaccOut, mk(1, 1, 8'h0C, 4'hF, 32'h2468_ACE0, 32'h8000_0060));
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
